cpri_rx_skew_buffer: RTL and testbench

- Receive-side counterpart of the transmit-path fixed register delay line.
- The TX side delays a stream by a fixed number of clocks. This block removes per-lane skew on the RX side by re-aligning a valid-qualified stream to a programmable delay counted in accepted words.
- Built on a circular RAM buffer, a write/read pointer pair and a fill state machine.
- Sits between the CPRI RX deframer and the antenna-carrier unpacker, one instance per lane.

---
 rtl/cpri_rx_skew_buffer.sv | 158 +++++++++++++++
 tb/tb_cpri_rx_skew_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_rx_skew_buffer.sv
// cpri_rx_skew_buffer
//   Per-lane RX deskew buffer. A valid-qualified word stream is re-aligned
//   so that the output lags the input by a programmable number of accepted
//   words. Storage is a circular RAM addressed by a write/read pointer pair.
//   A small fill state machine controls the pointers:
//     IDLE -> FILL -> RUN
//
//   Handshake: the interface has no backpressure. in_vld marks a word that
//   is always accepted. out_vld marks a word that is valid for exactly that
//   one cycle. out_data/out_sof hold their last value while out_vld is low.
//
//   Build option:
//     CPRI_RX_SKEW_RESYNC_EN  when defined, a start-of-frame that arrives in
//                             RUN restarts alignment. When undefined, such a
//                             start-of-frame is treated as ordinary data.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_delay  target delay in accepted words (0..DEPTH-1), sampled on sync
//   in_vld     input word valid
//   in_data    input word
//   in_sof     start-of-frame, qualified by in_vld
//   out_vld    output word valid (registered)
//   out_data   output word (registered)
//   out_sof    start-of-frame travelling with out_data (registered)
//   locked     high while the FSM is in RUN
module cpri_rx_skew_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int DLY_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             locked
);

`ifdef CPRI_RX_SKEW_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] wr_ptr, rd_ptr;
  logic [DLY_W-1:0] count_q;
  logic [DLY_W-1:0] dly_q;
  logic [WIDTH:0]   mem [DEPTH];

  logic             start;
  logic             wr_en;
  logic [DLY_W-1:0] wr_addr;
  logic             rd_en;
  logic             fwd;
  logic [WIDTH:0]   rd_word;
  logic [DLY_W-1:0] count_inc;

  always_comb begin
    start     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wr_ptr;
    rd_en     = 1'b0;
    fwd       = 1'b0;
    rd_word   = mem[rd_ptr];
    count_inc = count_q + DLY_W'(1);
    state_d   = state_q;

    // A start-of-frame (re)starts alignment from IDLE or FILL, and also
    // from RUN when resync is enabled.
    if (in_vld && in_sof) begin
      case (state_q)
        ST_IDLE: start = 1'b1;
        ST_FILL: start = 1'b1;
        ST_RUN:  start = RESYNC;
        default: start = 1'b0;
      endcase
    end

    // IDLE discards everything except the sof that opens a frame.
    wr_en   = in_vld && ((state_q != ST_IDLE) || in_sof);
    wr_addr = start ? '0 : wr_ptr;

    // A word is read in RUN, or on the sof itself when the new delay is 0.
    rd_en = in_vld && (start ? (cfg_delay == '0) : (state_q == ST_RUN));

    // With zero delay, the read and write addresses coincide, so the word
    // bypasses the RAM instead of reading a stale entry.
    fwd = start || (dly_q == '0);

    if (start) begin
      // The sof word itself counts as the first stored word. A delay of 1
      // is therefore already satisfied, and a delay of 0 emits immediately.
      state_d = (cfg_delay <= DLY_W'(1)) ? ST_RUN : ST_FILL;
    end else if ((state_q == ST_FILL) && in_vld && (count_inc == dly_q)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      dly_q    <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sof  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_vld <= rd_en;

      if (start) begin
        wr_ptr  <= DLY_W'(1);
        // On the zero-delay forward, the sof word is consumed as it is
        // written, so the read pointer moves with the write pointer.
        rd_ptr  <= rd_en ? DLY_W'(1) : '0;
        count_q <= DLY_W'(1);
        dly_q   <= cfg_delay;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + DLY_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + DLY_W'(1);
        if ((state_q == ST_FILL) && in_vld) count_q <= count_inc;
      end

      if (rd_en) begin
        if (fwd) begin
          out_data <= in_data;
          out_sof  <= in_sof;
        end else begin
          out_data <= rd_word[WIDTH-1:0];
          out_sof  <= rd_word[WIDTH];
        end
      end
    end
  end

  // The RAM has no reset; its contents are never read before being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_sof, in_data};
  end

  assign locked = (state_q == ST_RUN);

endmodule

// File: tb/tb_cpri_rx_skew_buffer.sv
// tb_cpri_rx_skew_buffer
//   Self-checking bench for cpri_rx_skew_buffer (WIDTH=32, DEPTH=16).
//   A queue-based reference model predicts every emitted word into exp_q.
//   The DUT outputs are sampled 1 ns after each rising edge.
module tb_cpri_rx_skew_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int DLY_W = 4;
  localparam int SW    = WIDTH + 1;

`ifdef CPRI_RX_SKEW_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic             in_vld = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sof = 1'b0;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_sof;
  logic             locked;

  always #5 clk = ~clk;

  cpri_rx_skew_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_delay (cfg_delay),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .locked    (locked)
  );

  // ---------------- scoreboard / model state ----------------
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] m_hist[$];
  int            m_d;
  bit            m_started;
  bit            m_locked;
  bit            m_emit;
  logic [SW-1:0] m_last;
  int            total;
  int            bad;
  int            out_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the words since the last accepted sof sit in a history queue.
  // Any word beyond the programmed delay falls out of the front as output.
  task automatic model_step(input logic v, input logic s, input logic [WIDTH-1:0] d);
    logic [SW-1:0] w;
    m_emit = 1'b0;
    if (v) begin
      if (s && (!m_started || !m_locked || RESYNC)) begin
        m_hist.delete();
        m_d       = int'(cfg_delay);
        m_started = 1'b1;
      end
      if (m_started) begin
        m_hist.push_back({s, d});
        if (m_hist.size() > m_d) begin
          w = m_hist.pop_front();
          exp_q.push_back(w);
          m_last = w;
          m_emit = 1'b1;
        end
        m_locked = (m_hist.size() >= m_d);
      end
    end
  endtask

  task automatic check_outputs();
    logic [SW-1:0] w;
    check("vld", 64'(out_vld), 64'(m_emit));
    check("locked", 64'(locked), 64'(m_locked));
    if (out_vld) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        w = exp_q.pop_front();
        check("data", 64'({out_sof, out_data}), 64'(w));
      end
    end else begin
      check("hold", 64'({out_sof, out_data}), 64'(m_last));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called 1 ns after a rising edge, and returns 1 ns after the next one.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_vld  = v;
    in_sof  = s;
    in_data = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hist.delete();
    m_d       = 0;
    m_started = 1'b0;
    m_locked  = 1'b0;
    m_emit    = 1'b0;
    m_last    = '0;
  endtask

  // Asserts reset between edges and checks that the outputs clear at once.
  task automatic do_reset();
    in_vld = 1'b0;
    in_sof = 1'b0;
    rst    = 1'b1;
    model_reset();
    #1;
    check("rst_vld", 64'(out_vld), 64'(0));
    check("rst_out", 64'({out_sof, out_data}), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] first_w;
    int            c0;
    total = 0;
    bad   = 0;
    out_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // cfg 3, continuous stream; word 0 carries sof
    cfg_delay = 4'd3;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, WIDTH'(i));
    check("t1_first", 64'({out_vld, out_sof, out_data}), {31'd0, 1'b1, 1'b1, 32'd0});
    for (int i = 4; i < 12; i++) step(1'b1, 1'b0, WIDTH'(i));

    // cfg 0: the sof word appears one clock later with no gap
    do_reset();
    cfg_delay = 4'd0;
    step(1'b1, 1'b1, 32'h10);
    check("t2_first", 64'({out_vld, out_sof, out_data}), {31'd0, 1'b1, 1'b1, 32'h10});
    check("t2_locked", 64'(locked), 64'(1));
    for (int i = 1; i < 6; i++) step(1'b1, 1'b0, WIDTH'(32'h10 + i));

    // cfg 15, 40 words with random gaps and pointer wrap. cfg wiggles are ignored.
    do_reset();
    cfg_delay = 4'd15;
    c0 = out_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) idle_step();
      step(1'b1, i == 0, WIDTH'(32'h100 + i));
      cfg_delay = DLY_W'($urandom_range(0, 15));
    end
    repeat (3) idle_step();
    check("t3_count", 64'(out_cnt - c0), 64'(25));

    // cfg 4: a second sof during FILL restarts alignment
    do_reset();
    cfg_delay = 4'd4;
    step(1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b0, 32'h201);
    step(1'b1, 1'b1, 32'h202);
    for (int i = 3; i < 6; i++) step(1'b1, 1'b0, WIDTH'(32'h200 + i));
    check("t4_quiet", 64'(out_vld), 64'(0));
    step(1'b1, 1'b0, 32'h206);
    first_w = {out_sof, out_data};
    check("t4_first", 64'({out_vld, first_w}), {30'd0, 1'b1, 1'b1, 32'h202});
    for (int i = 7; i < 10; i++) step(1'b1, 1'b0, WIDTH'(32'h200 + i));

    // Reset while in RUN with 5 buffered words, then no sof for 20 cycles
    do_reset();
    cfg_delay = 4'd5;
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, WIDTH'(32'h300 + i));
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, WIDTH'($urandom));

    // sof in RUN with cfg changed from 2 to 5
    do_reset();
    cfg_delay = 4'd2;
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, WIDTH'(32'h400 + i));
    cfg_delay = 4'd5;
    step(1'b1, 1'b1, 32'h406);
    check("t6_locked", 64'(locked), 64'(RESYNC ? 0 : 1));
    for (int i = 7; i < 16; i++) step(1'b1, 1'b0, WIDTH'(32'h400 + i));

    // Random mix of gaps, sofs and delays
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) cfg_delay = DLY_W'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, WIDTH'($urandom));
    end

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
